// File: rtl/stg_wb.sv
// Writeback stage: registers the EX results for one cycle, commits them to the GP/AR/SR
// files on the following edge, and serves operand reads to EX with the pending commit bypassed.
module stg_wb #(
  parameter int GP_COUNT = 16,
  parameter int AR_COUNT = 4,
  parameter int SR_COUNT = 4,
  parameter int FL_IDX   = 2,
  localparam int GP_IW = (GP_COUNT > 1) ? $clog2(GP_COUNT) : 1,
  localparam int AR_IW = (AR_COUNT > 1) ? $clog2(AR_COUNT) : 1,
  localparam int SR_IW = (SR_COUNT > 1) ? $clog2(SR_COUNT) : 1
) (
  input  logic             iw_clk,
  input  logic             iw_rst,
  input  logic             iw_stall,
  input  logic             iw_flush,
  input  logic [23:0]      iw_result,
  input  logic [GP_IW-1:0] iw_tgt_gp,
  input  logic             iw_tgt_gp_we,
  input  logic [47:0]      iw_ar_result,
  input  logic [AR_IW-1:0] iw_tgt_ar,
  input  logic             iw_tgt_ar_we,
  input  logic [47:0]      iw_sr_result,
  input  logic [SR_IW-1:0] iw_tgt_sr,
  input  logic             iw_tgt_sr_we,
  input  logic [GP_IW-1:0] iw_rd_gp_a,
  input  logic [GP_IW-1:0] iw_rd_gp_b,
  input  logic [AR_IW-1:0] iw_rd_ar_a,
  input  logic [AR_IW-1:0] iw_rd_ar_b,
  input  logic [SR_IW-1:0] iw_rd_sr_a,
  input  logic [SR_IW-1:0] iw_rd_sr_b,
  output logic [23:0]      ow_gp_a,
  output logic [23:0]      ow_gp_b,
  output logic [47:0]      ow_ar_a,
  output logic [47:0]      ow_ar_b,
  output logic [47:0]      ow_sr_a,
  output logic [47:0]      ow_sr_b,
  output logic [3:0]       ow_flags,
  output logic [31:0]      ow_retired
);

  localparam logic [SR_IW-1:0] FL_SEL = SR_IW'(FL_IDX);
  localparam bit FL_OK = (FL_IDX >= 0) && (FL_IDX < SR_COUNT);

  logic [23:0] gp_file [GP_COUNT];
  logic [47:0] ar_file [AR_COUNT];
  logic [47:0] sr_file [SR_COUNT];

  logic [23:0]      stg_result;
  logic [GP_IW-1:0] stg_tgt_gp;
  logic             stg_gp_we;
  logic [47:0]      stg_ar_result;
  logic [AR_IW-1:0] stg_tgt_ar;
  logic             stg_ar_we;
  logic [47:0]      stg_sr_result;
  logic [SR_IW-1:0] stg_tgt_sr;
  logic             stg_sr_we;
  logic [31:0]      retired;

  // Out-of-range targets (only possible with non-power-of-two counts) neither write nor bypass.
  logic gp_pend, ar_pend, sr_pend;
  assign gp_pend = stg_gp_we && (int'(stg_tgt_gp) < GP_COUNT);
  assign ar_pend = stg_ar_we && (int'(stg_tgt_ar) < AR_COUNT);
  assign sr_pend = stg_sr_we && (int'(stg_tgt_sr) < SR_COUNT);

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      for (int i = 0; i < GP_COUNT; i++) gp_file[i] <= '0;
      for (int i = 0; i < AR_COUNT; i++) ar_file[i] <= '0;
      for (int i = 0; i < SR_COUNT; i++) sr_file[i] <= '0;
      stg_result    <= '0;
      stg_tgt_gp    <= '0;
      stg_gp_we     <= 1'b0;
      stg_ar_result <= '0;
      stg_tgt_ar    <= '0;
      stg_ar_we     <= 1'b0;
      stg_sr_result <= '0;
      stg_tgt_sr    <= '0;
      stg_sr_we     <= 1'b0;
      retired       <= '0;
    end else begin
      if (gp_pend) gp_file[stg_tgt_gp] <= stg_result;
      if (ar_pend) ar_file[stg_tgt_ar] <= stg_ar_result;
      if (sr_pend) sr_file[stg_tgt_sr] <= stg_sr_result;
      if (stg_gp_we || stg_ar_we || stg_sr_we) retired <= retired + 32'd1;
      // A stall turns the stage into a bubble so the held entry commits only once.
      if (iw_stall) begin
        stg_gp_we <= 1'b0;
        stg_ar_we <= 1'b0;
        stg_sr_we <= 1'b0;
      end else begin
        stg_result    <= iw_result;
        stg_tgt_gp    <= iw_tgt_gp;
        stg_gp_we     <= iw_tgt_gp_we && !iw_flush;
        stg_ar_result <= iw_ar_result;
        stg_tgt_ar    <= iw_tgt_ar;
        stg_ar_we     <= iw_tgt_ar_we && !iw_flush;
        stg_sr_result <= iw_sr_result;
        stg_tgt_sr    <= iw_tgt_sr;
        stg_sr_we     <= iw_tgt_sr_we && !iw_flush;
      end
    end
  end

  function automatic logic [23:0] rd_gp(input logic [GP_IW-1:0] idx);
    if (gp_pend && stg_tgt_gp == idx) return stg_result;
    if (int'(idx) < GP_COUNT) return gp_file[idx];
    return '0;
  endfunction

  function automatic logic [47:0] rd_ar(input logic [AR_IW-1:0] idx);
    if (ar_pend && stg_tgt_ar == idx) return stg_ar_result;
    if (int'(idx) < AR_COUNT) return ar_file[idx];
    return '0;
  endfunction

  function automatic logic [47:0] rd_sr(input logic [SR_IW-1:0] idx);
    if (sr_pend && stg_tgt_sr == idx) return stg_sr_result;
    if (int'(idx) < SR_COUNT) return sr_file[idx];
    return '0;
  endfunction

  assign ow_gp_a = rd_gp(iw_rd_gp_a);
  assign ow_gp_b = rd_gp(iw_rd_gp_b);
  assign ow_ar_a = rd_ar(iw_rd_ar_a);
  assign ow_ar_b = rd_ar(iw_rd_ar_b);
  assign ow_sr_a = rd_sr(iw_rd_sr_a);
  assign ow_sr_b = rd_sr(iw_rd_sr_b);

  assign ow_flags = !FL_OK ? 4'h0 :
                    (sr_pend && stg_tgt_sr == FL_SEL) ? stg_sr_result[3:0] :
                    sr_file[FL_SEL][3:0];

  assign ow_retired = retired;

endmodule

// File: tb/tb_stg_wb.sv
// Bench for stg_wb: a register-file model with one pending commit slot, compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_stg_wb;

  typedef struct {
    logic        rst, stall, flush;
    logic [23:0] result;
    logic [3:0]  tgt_gp;
    logic        gp_we;
    logic [47:0] ar_result;
    logic [1:0]  tgt_ar;
    logic        ar_we;
    logic [47:0] sr_result;
    logic [1:0]  tgt_sr;
    logic        sr_we;
    logic [3:0]  rd_gp_a, rd_gp_b;
    logic [1:0]  rd_ar_a, rd_ar_b, rd_sr_a, rd_sr_b;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush;
  logic [23:0] result;
  logic [3:0]  tgt_gp;
  logic        gp_we;
  logic [47:0] ar_result;
  logic [1:0]  tgt_ar;
  logic        ar_we;
  logic [47:0] sr_result;
  logic [1:0]  tgt_sr;
  logic        sr_we;
  logic [3:0]  rd_gp_a, rd_gp_b;
  logic [1:0]  rd_ar_a, rd_ar_b, rd_sr_a, rd_sr_b;
  logic [23:0] gp_a, gp_b;
  logic [47:0] ar_a, ar_b, sr_a, sr_b;
  logic [3:0]  flags;
  logic [31:0] retired;

  stg_wb dut (
    .iw_clk(clk), .iw_rst(rst), .iw_stall(stall), .iw_flush(flush),
    .iw_result(result), .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we),
    .iw_ar_result(ar_result), .iw_tgt_ar(tgt_ar), .iw_tgt_ar_we(ar_we),
    .iw_sr_result(sr_result), .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we),
    .iw_rd_gp_a(rd_gp_a), .iw_rd_gp_b(rd_gp_b),
    .iw_rd_ar_a(rd_ar_a), .iw_rd_ar_b(rd_ar_b),
    .iw_rd_sr_a(rd_sr_a), .iw_rd_sr_b(rd_sr_b),
    .ow_gp_a(gp_a), .ow_gp_b(gp_b), .ow_ar_a(ar_a), .ow_ar_b(ar_b),
    .ow_sr_a(sr_a), .ow_sr_b(sr_b), .ow_flags(flags), .ow_retired(retired)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model: committed files plus the single accepted-but-uncommitted entry.
  stim_t       cur;
  logic [23:0] m_gp [16];
  logic [47:0] m_ar [4];
  logic [47:0] m_sr [4];
  bit          p_valid = 1'b0;
  stim_t       p;
  int unsigned m_retired = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    if (cur.rst) begin
      for (int i = 0; i < 16; i++) m_gp[i] = '0;
      for (int i = 0; i < 4; i++) begin m_ar[i] = '0; m_sr[i] = '0; end
      p_valid   = 1'b0;
      m_retired = 0;
      started   = 1'b1;
    end else begin
      if (p_valid) begin
        if (p.gp_we) m_gp[p.tgt_gp] = p.result;
        if (p.ar_we) m_ar[p.tgt_ar] = p.ar_result;
        if (p.sr_we) m_sr[p.tgt_sr] = p.sr_result;
        m_retired = m_retired + 1;
      end
      p_valid = !cur.stall && !cur.flush && (cur.gp_we || cur.ar_we || cur.sr_we);
      p = cur;
    end
  end

  function automatic logic [23:0] exp_gp(input logic [3:0] i);
    return (p_valid && p.gp_we && p.tgt_gp == i) ? p.result : m_gp[i];
  endfunction
  function automatic logic [47:0] exp_ar(input logic [1:0] i);
    return (p_valid && p.ar_we && p.tgt_ar == i) ? p.ar_result : m_ar[i];
  endfunction
  function automatic logic [47:0] exp_sr(input logic [1:0] i);
    return (p_valid && p.sr_we && p.tgt_sr == i) ? p.sr_result : m_sr[i];
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [47:0] fw;
    if (!started) return;
    fw = exp_sr(2'd2);
    compare("gp_a", gp_a, exp_gp(rd_gp_a));
    compare("gp_b", gp_b, exp_gp(rd_gp_b));
    compare("ar_a", ar_a, exp_ar(rd_ar_a));
    compare("ar_b", ar_b, exp_ar(rd_ar_b));
    compare("sr_a", sr_a, exp_sr(rd_sr_a));
    compare("sr_b", sr_b, exp_sr(rd_sr_b));
    compare("flags", flags, fw[3:0]);
    compare("retired", retired, m_retired);
  endtask

  task automatic applyStimulus(input stim_t s);
    cur = s;
    rst = s.rst; stall = s.stall; flush = s.flush;
    result = s.result; tgt_gp = s.tgt_gp; gp_we = s.gp_we;
    ar_result = s.ar_result; tgt_ar = s.tgt_ar; ar_we = s.ar_we;
    sr_result = s.sr_result; tgt_sr = s.tgt_sr; sr_we = s.sr_we;
    rd_gp_a = s.rd_gp_a; rd_gp_b = s.rd_gp_b;
    rd_ar_a = s.rd_ar_a; rd_ar_b = s.rd_ar_b;
    rd_sr_a = s.rd_sr_a; rd_sr_b = s.rd_sr_b;
  endtask

  // Checks the cycle just finished, then presents the next inputs for the coming edge.
  task automatic step(input stim_t s);
    @(negedge clk);
    checkOutput();
    applyStimulus(s);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    step(s);
    s.rst = 1'b0;
    step(s);
    compare("reset_gp", gp_a, 24'h0);
    compare("reset_flags", flags, 4'h0);
    compare("reset_retired", retired, 32'd0);

    // GP5 write: bypass after capture, file value after commit
    s = idle(); s.result = 24'h123456; s.tgt_gp = 4'd5; s.gp_we = 1'b1; s.rd_gp_a = 4'd5;
    step(s);
    s = idle(); s.rd_gp_a = 4'd5;
    step(s);
    compare("gp5_bypass", gp_a, 24'h123456);
    compare("gp5_not_retired", retired, 32'd0);
    step(s);
    compare("gp5_commit", gp_a, 24'h123456);
    compare("gp5_retired", retired, 32'd1);

    // Flags through SR2
    s = idle(); s.sr_result = 48'h9; s.tgt_sr = 2'd2; s.sr_we = 1'b1; s.rd_sr_a = 2'd1;
    step(s);
    s = idle(); s.rd_sr_a = 2'd1;
    step(s);
    compare("flags_bypass", flags, 4'b1001);
    compare("sr1_zero", sr_a, 48'h0);
    step(s);
    compare("flags_commit", flags, 4'b1001);
    compare("sr_retired", retired, 32'd2);

    // Captured entry followed by three stalled edges: one commit only
    s = idle(); s.result = 24'hFFFF80; s.tgt_gp = 4'd3; s.gp_we = 1'b1; s.rd_gp_a = 4'd3;
    step(s);
    s = idle(); s.stall = 1'b1; s.result = 24'h111111; s.tgt_gp = 4'd3; s.gp_we = 1'b1;
    s.rd_gp_a = 4'd3;
    repeat (3) step(s);
    s = idle(); s.rd_gp_a = 4'd3;
    step(s);
    compare("stall_gp3", gp_a, 24'hFFFF80);
    compare("stall_retired", retired, 32'd3);

    // Flushed entry never becomes visible
    s = idle(); s.flush = 1'b1; s.result = 24'hAAAAAA; s.tgt_gp = 4'd7; s.gp_we = 1'b1;
    s.rd_gp_a = 4'd7;
    step(s);
    s = idle(); s.rd_gp_a = 4'd7;
    step(s);
    compare("flush_bypass", gp_a, 24'h0);
    step(s);
    compare("flush_gp7", gp_a, 24'h0);
    compare("flush_retired", retired, 32'd3);

    // Back-to-back writes to GP2
    s = idle(); s.result = 24'h000010; s.tgt_gp = 4'd2; s.gp_we = 1'b1; s.rd_gp_a = 4'd2;
    step(s);
    s.result = 24'h000012;
    step(s);
    compare("b2b_first", gp_a, 24'h000010);
    s = idle(); s.rd_gp_a = 4'd2;
    step(s);
    compare("b2b_second", gp_a, 24'h000012);
    step(s);
    compare("b2b_final", gp_a, 24'h000012);
    compare("b2b_retired", retired, 32'd5);

    // One entry writing all three files
    s = idle(); s.rd_gp_a = 4'd9; s.rd_ar_a = 2'd1; s.rd_sr_a = 2'd2;
    s.result = 24'h0ABCDE; s.tgt_gp = 4'd9; s.gp_we = 1'b1;
    s.ar_result = 48'h0000_1234_5678; s.tgt_ar = 2'd1; s.ar_we = 1'b1;
    s.sr_result = 48'h1; s.tgt_sr = 2'd2; s.sr_we = 1'b1;
    step(s);
    s.gp_we = 1'b0; s.ar_we = 1'b0; s.sr_we = 1'b0;
    step(s);
    step(s);
    compare("multi_gp", gp_a, 24'h0ABCDE);
    compare("multi_ar", ar_a, 48'h0000_1234_5678);
    compare("multi_sr", sr_a, 48'h1);
    compare("multi_flags", flags, 4'h1);
    compare("multi_retired", retired, 32'd6);

    // Reset with an entry pending wipes everything
    s.result = 24'h555555; s.gp_we = 1'b1;
    step(s);
    s.rst = 1'b1;
    step(s);
    s = idle(); s.rd_gp_a = 4'd9; s.rd_ar_a = 2'd1; s.rd_sr_a = 2'd2;
    step(s);
    compare("rst_gp", gp_a, 24'h0);
    compare("rst_ar", ar_a, 48'h0);
    compare("rst_sr", sr_a, 48'h0);
    compare("rst_flags", flags, 4'h0);
    compare("rst_retired", retired, 32'd0);

    // Random traffic with narrow target ranges so collisions and bypasses are frequent
    for (int n = 0; n < 3000; n++) begin
      s.rst       = ($urandom_range(0, 199) == 0);
      s.stall     = ($urandom_range(0, 5) == 0);
      s.flush     = ($urandom_range(0, 7) == 0);
      s.result    = 24'($urandom);
      s.tgt_gp    = 4'($urandom_range(0, 7));
      s.gp_we     = 1'($urandom);
      s.ar_result = {16'($urandom), 32'($urandom)};
      s.tgt_ar    = 2'($urandom);
      s.ar_we     = 1'($urandom);
      s.sr_result = {16'($urandom), 32'($urandom)};
      s.tgt_sr    = 2'($urandom);
      s.sr_we     = 1'($urandom);
      s.rd_gp_a   = 4'($urandom_range(0, 7));
      s.rd_gp_b   = 4'($urandom);
      s.rd_ar_a   = 2'($urandom);
      s.rd_ar_b   = 2'($urandom);
      s.rd_sr_a   = 2'($urandom);
      s.rd_sr_b   = 2'($urandom);
      step(s);
    end
    step(idle());
    step(idle());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stg_wb.md
Name: stg_wb

Overview:
- Writeback stage. It is the write end of the register interface whose read end is the execute stage.
- It captures the EX outputs (result, AR result, SR result, targets and write enables) into a WB stage register and commits them one cycle later.
- It owns the GP, AR and SR register files.
- It sources the `*_val` operand buckets that EX consumes, with bypass of the pending commit, and keeps a retired-write counter.

Parameters:
- GP_COUNT, 16, number of 24-bit general-purpose registers (index width 4)
- AR_COUNT, 4, number of 48-bit address registers (index width 2)
- SR_COUNT, 4, number of 48-bit special registers (index width 2)
- FL_IDX, 2, SR index holding flags: bit0 Z, bit1 N, bit2 C, bit3 V

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  synchronous reset, active-high
- iw_stall  in  1  pipeline stall
- iw_flush  in  1  discard the entry presented this cycle
- iw_result  in  24  GP write data (EX ow_result)
- iw_tgt_gp  in  4  GP write index
- iw_tgt_gp_we  in  1  GP write enable
- iw_ar_result  in  48  AR write data
- iw_tgt_ar  in  2  AR write index
- iw_tgt_ar_we  in  1  AR write enable
- iw_sr_result  in  48  SR write data
- iw_tgt_sr  in  2  SR write index
- iw_tgt_sr_we  in  1  SR write enable
- iw_rd_gp_a, iw_rd_gp_b  in  4 each  GP read indices (src/tgt)
- iw_rd_ar_a, iw_rd_ar_b  in  2 each  AR read indices
- iw_rd_sr_a, iw_rd_sr_b  in  2 each  SR read indices
- ow_gp_a, ow_gp_b  out  24 each  GP read data
- ow_ar_a, ow_ar_b  out  48 each  AR read data
- ow_sr_a, ow_sr_b  out  48 each  SR read data
- ow_flags  out  4  SR[FL_IDX][3:0], bypassed
- ow_retired  out  32  count of committed WB entries with at least one enable set

Behaviour:
- **Reset:** clears all GP, AR and SR registers, the WB stage register (all enables 0) and ow_retired to 0. Every read output is therefore 0 in the cycle after reset. Reset overrides stall and flush.
- **Stage register load:** on each posedge with !iw_rst and !iw_stall, the stage register loads the inputs. If iw_flush is set, the three enables are loaded as 0; the data fields are don't-care.
- **Stall:** on a posedge with iw_stall, the stage register data holds but its enables clear to 0 (bubble). The held entry therefore commits exactly once.
- **Commit:** on each posedge, every set enable in the stage register writes its file. GP, AR and SR writes in the same entry are independent and all take effect. Latency from input to architectural state is 2 edges.
- **Read path:** reads are combinational from the files. If a read index matches a valid pending stage-register write of the same file, the output returns the stage-register data instead. This bypass gives zero-bubble forwarding of WB into EX.
- **ow_flags:** follows the SR read path with index FL_IDX, including the bypass.
- **Write collision:** a pending write and an incoming entry to the same index are legal. The pending one commits this edge; the incoming one commits next edge (program order).
- **ow_retired:** increments by 1 at each commit edge where the stage register has any enable set. It wraps modulo 2^32. A bubble, flushed or stalled cycle does not count.
- **Data widths:** data is written at full width, with no masking or extension. SR[FL_IDX] stores all 48 bits.
- **Parameter range:** indices at or beyond COUNT are impossible for the default parameters. For non-default parameters, an out-of-range write is ignored and an out-of-range read returns 0.

Test Plan:
- Reset, then write GP5=0x123456 with gp_we=1, then rd_gp_a=5 → ow_gp_a=0x123456 one edge after capture (bypass). It still reads 0x123456 after commit; ow_retired=1.
- SR write to idx 2 with 0x000000000009 → ow_flags=4'b1001 via bypass in the following cycle, and after commit; SR1 still reads 0.
- Stall: present GP3=0xFFFF80 with stall held high for 3 cycles → GP3=0xFFFF80 written once; ow_retired increments by exactly 1.
- Flush with GP7=0xAAAAAA and gp_we=1 → GP7 stays 0; ow_retired unchanged.
- Back-to-back GP2=0x000010 then GP2=0x000012 → rd_gp_a=2 shows 0x000010, then 0x000012; the final file value is 0x000012.
- Single entry with gp_we, ar_we (AR1=0x0000_1234_5678) and sr_we (SR2=0x1) → all three update; ow_retired +1. Assert iw_rst mid-sequence → all outputs 0 on the next edge.
